// File: rtl/core_types_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// operand-forward select encoding.
package core_types_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } hazard_state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

   // MEM result is younger than WB, so it wins when both match.
   function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
      if (mem_hit) return FWD_MEM;
      if (wb_hit) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for in-flight register writers. A set and a clear of
// the same register in one cycle leaves the bit set.
module reg_scoreboard #(
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     nReset,
   input  logic                     set_en,
   input  logic [$clog2(NREGS)-1:0] set_idx,
   input  logic                     clr_en,
   input  logic [$clog2(NREGS)-1:0] clr_idx,
   input  logic [$clog2(NREGS)-1:0] rs1,
   input  logic [$clog2(NREGS)-1:0] rs2,
   output logic                     busy_rs1,
   output logic                     busy_rs2
);

   logic [NREGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_idx] = 1'b0;
      if (set_en) busy_d[set_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   assign busy_rs1 = busy_q[rs1];
   assign busy_rs2 = busy_q[rs2];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / bubble / flush / freeze sequencing for the 5-stage pipe.
// FORWARDING_EN selects load-use detection plus forwarding; otherwise a busy scoreboard.
//
//  state    | meaning
//  RUN      | normal issue, data hazards stall IF/ID
//  FLUSH    | extra flush_id cycles after a redirect
//  MEM_WAIT | data memory access outstanding, pipe frozen
module pipeline_hazard_ctrl
   import core_types_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int NREGS        = 32
) (
   input  logic                     clk,
   input  logic                     nReset,
   input  logic                     id_valid,
   input  logic [$clog2(NREGS)-1:0] id_rs1,
   input  logic [$clog2(NREGS)-1:0] id_rs2,
   input  logic                     id_use_rs1,
   input  logic                     id_use_rs2,
   input  logic [$clog2(NREGS)-1:0] id_rd,
   input  logic                     id_wreg,
   input  logic [$clog2(NREGS)-1:0] ex_rd,
   input  logic                     ex_wreg,
   input  logic                     ex_isload,
   input  logic [$clog2(NREGS)-1:0] mem_rd,
   input  logic                     mem_wreg,
   input  logic                     mem_access,
   input  logic [$clog2(NREGS)-1:0] wb_rd,
   input  logic                     wb_wreg,
   input  logic                     redirect,
   input  logic                     dmem_ready,
   output logic                     stall_if,
   output logic                     stall_id,
   output logic                     bubble_ex,
   output logic                     flush_id,
   output logic                     freeze,
   output logic [1:0]               fwd_a,
   output logic [1:0]               fwd_b,
   output logic [1:0]               state_o
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   hazard_state_t state_q;
   logic [1:0]    flush_cnt_q;
   logic          freeze_c;
   logic          hazard_c;
   fwd_sel_t      fwd_a_c, fwd_b_c;

   assign freeze_c = mem_access & ~dmem_ready;

`ifdef FORWARDING_EN
   logic unused_fwd_build;

   assign hazard_c = id_valid & ex_isload & ex_wreg & (|ex_rd) &
                     ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
   assign fwd_a_c  = fwd_pick(mem_wreg & (|mem_rd) & (mem_rd == id_rs1),
                              wb_wreg & (|wb_rd) & (wb_rd == id_rs1));
   assign fwd_b_c  = fwd_pick(mem_wreg & (|mem_rd) & (mem_rd == id_rs2),
                              wb_wreg & (|wb_rd) & (wb_rd == id_rs2));
   assign unused_fwd_build = ^{id_rd, id_wreg};
`else
   logic busy_rs1, busy_rs2, issue_c;
   logic unused_sb_build;

   // An ID instruction only claims its destination once it actually leaves ID.
   assign issue_c = id_valid & id_wreg & (|id_rd) & ~(stall_id | flush_id | freeze);

   reg_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk      (clk),
      .nReset   (nReset),
      .set_en   (issue_c),
      .set_idx  (id_rd),
      .clr_en   (wb_wreg),
      .clr_idx  (wb_rd),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .busy_rs1 (busy_rs1),
      .busy_rs2 (busy_rs2)
   );

   assign hazard_c = id_valid & ((id_use_rs1 & busy_rs1) | (id_use_rs2 & busy_rs2));
   assign fwd_a_c  = FWD_RF;
   assign fwd_b_c  = FWD_RF;
   assign unused_sb_build = ^{ex_rd, ex_wreg, ex_isload, mem_rd, mem_wreg};
`endif

   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      freeze    = 1'b0;
      fwd_a     = FWD_RF;
      fwd_b     = FWD_RF;
      if (nReset) begin
         if (freeze_c) begin
            freeze = 1'b1;
         end else begin
            fwd_a = fwd_a_c;
            fwd_b = fwd_b_c;
            if (redirect) begin
               flush_id  = 1'b1;
               bubble_ex = 1'b1;
            end else if (state_q == FLUSH) begin
               flush_id = 1'b1;
            end else if (hazard_c) begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
            end
         end
      end
   end

   // A redirect held in EX during a freeze is taken on the release cycle.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (freeze_c) begin
                  state_q <= MEM_WAIT;
               end else if (redirect && FLUSH_CYCLES > 1) begin
                  state_q     <= FLUSH;
                  flush_cnt_q <= FLUSH_LOAD;
               end
            end
            MEM_WAIT: begin
               if (!freeze_c) begin
                  if (redirect && FLUSH_CYCLES > 1) begin
                     state_q     <= FLUSH;
                     flush_cnt_q <= FLUSH_LOAD;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            FLUSH: begin
               if (!freeze_c) begin
                  if (redirect) begin
                     flush_cnt_q <= FLUSH_LOAD;
                  end else if (flush_cnt_q == 2'd1) begin
                     state_q     <= RUN;
                     flush_cnt_q <= '0;
                  end else begin
                     flush_cnt_q <= flush_cnt_q - 2'd1;
                  end
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2); covers both
// the default scoreboard build and the FORWARDING_EN build.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       nReset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_wreg;
   logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
   logic       ex_wreg, ex_isload, mem_wreg, mem_access, wb_wreg;
   logic       redirect, dmem_ready;
   logic       stall_if, stall_id, bubble_ex, flush_id, freeze;
   logic [1:0] fwd_a, fwd_b, state_o;
   logic [10:0] obs;

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];
   string       tag_q[$];

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .NREGS(32)) dut (
      .clk(clk), .nReset(nReset),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_wreg(id_wreg),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_isload(ex_isload),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_access(mem_access),
      .wb_rd(wb_rd), .wb_wreg(wb_wreg),
      .redirect(redirect), .dmem_ready(dmem_ready),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .flush_id(flush_id), .freeze(freeze),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign obs = {stall_if, stall_id, bubble_ex, flush_id, freeze, fwd_a, fwd_b, state_o};

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   // Bit order: stall_if stall_id bubble_ex flush_id freeze fwd_a fwd_b state
   function automatic logic [10:0] E(input logic si, input logic sd, input logic bx,
                                     input logic fl, input logic fz, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [1:0] st);
      return {si, sd, bx, fl, fz, fa, fb, st};
   endfunction

   localparam logic [10:0] Z     = 11'b0;
   localparam logic [10:0] STALL = 11'b111_0_0_00_00_00;

   task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b (si sd bx fl fz fa fb st)", tag, got, want);
      end
   endtask

   task automatic cyc(input string tag, input logic [10:0] exp);
      string t;
      logic [10:0] e;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, obs, e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_wreg = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      ex_rd = 0; ex_wreg = 0; ex_isload = 0;
      mem_rd = 0; mem_wreg = 0; mem_access = 0;
      wb_rd = 0; wb_wreg = 0;
      redirect = 0; dmem_ready = 0;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic w);
      id_valid = v; id_rs1 = rs1; id_use_rs1 = u1;
      id_rs2 = rs2; id_use_rs2 = u2; id_rd = rd; id_wreg = w;
   endtask

   initial begin
      nReset = 0;
      idle();
      cyc("reset", Z);
      nReset = 1;
      cyc("run_idle", Z);

`ifdef FORWARDING_EN
      // load-use stall then MEM forward
      ex_isload = 1; ex_wreg = 1; ex_rd = 5; set_id(1, 5, 1, 1, 1, 6, 1);
      cyc("load_use", STALL);
      ex_isload = 0; ex_wreg = 0; ex_rd = 0;
      mem_rd = 5; mem_wreg = 1; mem_access = 1; dmem_ready = 1;
      cyc("load_fwd", E(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'd0));
      idle(); ex_wreg = 1; ex_rd = 5; set_id(1, 5, 1, 0, 0, 0, 0);
      cyc("alu_no_stall", Z);
      ex_isload = 1; ex_rd = 0; set_id(1, 0, 1, 0, 1, 0, 0);
      cyc("load_x0", Z);
      ex_rd = 4; set_id(1, 1, 1, 4, 0, 0, 0);
      cyc("load_unused", Z);
      id_use_rs2 = 1;
      cyc("load_rs2", STALL);
      idle(); mem_rd = 3; mem_wreg = 1; wb_rd = 3; wb_wreg = 1; set_id(1, 3, 1, 3, 1, 0, 0);
      cyc("mem_beats_wb", E(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'd0));
      mem_wreg = 0;
      cyc("wb_fwd", E(0, 0, 0, 0, 0, 2'b10, 2'b10, 2'd0));
      mem_rd = 0; mem_wreg = 1; wb_wreg = 0; set_id(1, 0, 1, 0, 1, 0, 0);
      cyc("x0_no_fwd", Z);
      mem_rd = 3; mem_wreg = 1; wb_rd = 4; wb_wreg = 1; set_id(1, 3, 1, 4, 1, 0, 0);
      cyc("fwd_mixed", E(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'd0));
      mem_access = 1; dmem_ready = 0;
      cyc("fwd_frozen", E(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0));
      dmem_ready = 1;
      cyc("fwd_release", E(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'd2));
      idle();
      cyc("fwd_idle", Z);
`else
      // scoreboard RAW sequence
      set_id(1, 1, 1, 0, 0, 7, 1);
      cyc("issue_x7", Z);
      set_id(1, 7, 1, 2, 1, 8, 1);
      cyc("raw_x7_a", STALL);
      cyc("raw_x7_b", STALL);
      wb_wreg = 1; wb_rd = 7;
      cyc("raw_x7_wb", STALL);
      wb_wreg = 0;
      cyc("x7_free", Z);
      set_id(1, 3, 1, 8, 1, 0, 0);
      cyc("raw_x8_rs2", STALL);
      id_use_rs2 = 0;
      cyc("rs2_unused", Z);
      set_id(0, 3, 1, 8, 1, 0, 0);
      cyc("id_invalid", Z);
      set_id(1, 0, 0, 0, 0, 0, 1);
      cyc("issue_x0", Z);
      set_id(1, 0, 1, 0, 1, 9, 1); wb_wreg = 1; wb_rd = 9;
      cyc("set_clr_x9", Z);
      wb_wreg = 0; set_id(1, 9, 1, 0, 0, 0, 0);
      cyc("x9_set_wins", STALL);
      wb_wreg = 1; wb_rd = 9;
      cyc("x9_wb", STALL);
      wb_wreg = 0;
      cyc("x9_free", Z);
      set_id(1, 8, 1, 0, 0, 10, 1); redirect = 1;
      cyc("sb_redir", E(0, 0, 1, 1, 0, 0, 0, 2'd0));
      redirect = 0; set_id(1, 10, 1, 0, 0, 0, 0);
      cyc("sb_flush_st", E(0, 0, 0, 1, 0, 0, 0, 2'd1));
      cyc("x10_squashed", Z);
      set_id(1, 8, 1, 0, 0, 0, 0);
      cyc("x8_kept", STALL);
      idle(); mem_rd = 3; mem_wreg = 1; wb_rd = 3; wb_wreg = 1; set_id(1, 3, 1, 3, 1, 0, 0);
      cyc("no_fwd", Z);
`endif

      // redirect with FLUSH_CYCLES=2
      idle(); redirect = 1;
      cyc("redir", E(0, 0, 1, 1, 0, 0, 0, 2'd0));
      redirect = 0;
      cyc("flush_st", E(0, 0, 0, 1, 0, 0, 0, 2'd1));
      cyc("flush_done", Z);

      // freeze dominates redirect and hazards, redirect taken on release
      mem_access = 1; dmem_ready = 0; redirect = 1; set_id(1, 8, 1, 0, 0, 11, 1);
      cyc("frz_0", E(0, 0, 0, 0, 1, 0, 0, 2'd0));
      cyc("frz_1", E(0, 0, 0, 0, 1, 0, 0, 2'd2));
      cyc("frz_2", E(0, 0, 0, 0, 1, 0, 0, 2'd2));
      dmem_ready = 1;
      cyc("frz_release", E(0, 0, 1, 1, 0, 0, 0, 2'd2));
      idle();
      cyc("frz_flush2", E(0, 0, 0, 1, 0, 0, 0, 2'd1));
      cyc("frz_done", Z);
      set_id(1, 11, 1, 0, 0, 0, 0);
      cyc("x11_squashed", Z);
`ifndef FORWARDING_EN
      set_id(1, 8, 1, 0, 0, 0, 0);
      cyc("x8_still_busy", STALL);
`endif

      // async reset mid-FLUSH with busy bits set
      idle(); redirect = 1;
      cyc("redir_pre_rst", E(0, 0, 1, 1, 0, 0, 0, 2'd0));
      nReset = 0;
      set_id(1, 8, 1, 0, 0, 0, 0); mem_access = 1; dmem_ready = 0;
      cyc("rst_mid_flush", Z);
      nReset = 1;
      idle(); set_id(1, 8, 1, 0, 0, 0, 0);
      cyc("sb_cleared", Z);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
